// File: rtl/dpll_pkg.sv
// dpll_pkg: shared phase-detector state type and default parameters for the DPLL phase/K-counter stage.
package dpll_pkg;
    typedef enum logic [1:0] {IDLE, REF_LEAD, FB_LEAD} pd_state_t;
    localparam int K_MOD_DEF    = 16;
    localparam int ERR_W_DEF    = 12;
    localparam int LOCK_TOL_DEF = 2;
    localparam int LOCK_CNT_DEF = 8;
endpackage

// File: rtl/dpll_phase_kcounter_if.sv
// dpll_phase_kcounter_if: level inputs and registered outputs of the DPLL phase detector / K-counter stage.
interface dpll_phase_kcounter_if import dpll_pkg::*; #(parameter int ERR_W = ERR_W_DEF);
    logic en, ref_in, fb_in;
    logic dn_up_o, carry_o, borrow_o, err_valid_o, slip_o, lock_o;
    logic signed [ERR_W-1:0] phase_err_o;
    modport master (output en, ref_in, fb_in,
                    input dn_up_o, carry_o, borrow_o, phase_err_o, err_valid_o, slip_o, lock_o);
    modport slave  (input en, ref_in, fb_in,
                    output dn_up_o, carry_o, borrow_o, phase_err_o, err_valid_o, slip_o, lock_o);
endinterface

// File: rtl/dpll_kcounter.sv
// dpll_kcounter: pair of modulo-K counters; carry on up-count wrap, borrow on down-count wrap.
module dpll_kcounter import dpll_pkg::*; #(parameter int K_MOD = K_MOD_DEF) (
    input  logic clk_in,
    input  logic rst,
    input  logic i_en,
    input  logic i_dn_up,
    output logic o_carry,
    output logic o_borrow
);
    localparam int CW = (K_MOD > 2) ? $clog2(K_MOD) : 1;
    localparam logic [CW-1:0] TOP = CW'(K_MOD - 1);
    logic [CW-1:0] r_up_cnt, r_dn_cnt;
    logic w_up, w_dn;
    assign w_up = i_en & ~i_dn_up;
    assign w_dn = i_en & i_dn_up;
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_up_cnt <= '0;
            r_dn_cnt <= '0;
            o_carry  <= 1'b0;
            o_borrow <= 1'b0;
        end else begin
            if (w_up) r_up_cnt <= (r_up_cnt == TOP) ? '0 : r_up_cnt + 1'b1;
            if (w_dn) r_dn_cnt <= (r_dn_cnt == TOP) ? '0 : r_dn_cnt + 1'b1;
            o_carry  <= w_up && (r_up_cnt == TOP);
            o_borrow <= w_dn && (r_dn_cnt == TOP);
        end
    end
endmodule

// File: rtl/dpll_phase_kcounter.sv
// dpll_phase_kcounter: XOR/edge phase detector, K-counter loop filter and lock monitor.
// Define DPLL_PD_SYNC_EN to put a 2-flop synchronizer on ref_in/fb_in (adds 2 cycles to every output path).
module dpll_phase_kcounter import dpll_pkg::*; #(
    parameter int K_MOD    = K_MOD_DEF,
    parameter int ERR_W    = ERR_W_DEF,
    parameter int LOCK_TOL = LOCK_TOL_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input logic clk_in,
    input logic rst,
    dpll_phase_kcounter_if.slave bus
);
`ifdef DPLL_PD_SYNC_EN
    localparam int STG = 3;
`else
    localparam int STG = 1;
`endif
    localparam int CW = ERR_W - 1;
    localparam logic [CW-1:0] ERR_MAX = '1;
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam logic [LW-1:0] LC_MAX = LW'(LOCK_CNT);
    localparam logic signed [ERR_W-1:0] TOL = ERR_W'(LOCK_TOL);
    logic [STG-1:0] r_ref_sh, r_fb_sh;
    logic r_ref_d, r_fb_d;
    pd_state_t r_state;
    logic [CW-1:0] r_err_cnt;
    logic [LW-1:0] r_lock_cnt;
    logic w_ref_s, w_fb_s, w_r, w_f, w_open, w_close, w_in_tol;
    logic signed [ERR_W-1:0] w_mag, w_err;
    logic [LW-1:0] w_lock_nx;
    assign w_ref_s = r_ref_sh[STG-1];
    assign w_fb_s  = r_fb_sh[STG-1];
    assign w_r     = w_ref_s & ~r_ref_d;
    assign w_f     = w_fb_s & ~r_fb_d;
    // In FB_LEAD the roles of the two edges swap and the error is negated.
    assign w_close = (r_state == FB_LEAD) ? w_r : w_f;
    assign w_open  = (r_state == FB_LEAD) ? w_f : w_r;
    assign w_mag   = {1'b0, r_err_cnt};
    assign w_err   = (r_state == FB_LEAD) ? -w_mag : w_mag;
    assign w_in_tol = (bus.phase_err_o <= TOL) && (bus.phase_err_o >= -TOL);
    always_comb
        w_lock_nx = (bus.slip_o || (bus.err_valid_o && !w_in_tol)) ? '0 :
                    (bus.err_valid_o && r_lock_cnt != LC_MAX) ? r_lock_cnt + 1'b1 : r_lock_cnt;
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_ref_sh        <= '0;
            r_fb_sh         <= '0;
            r_ref_d         <= 1'b0;
            r_fb_d          <= 1'b0;
            r_state         <= IDLE;
            r_err_cnt       <= '0;
            r_lock_cnt      <= '0;
            bus.dn_up_o     <= 1'b0;
            bus.phase_err_o <= '0;
            bus.err_valid_o <= 1'b0;
            bus.slip_o      <= 1'b0;
            bus.lock_o      <= 1'b0;
        end else begin
            r_ref_sh        <= STG'({r_ref_sh, bus.ref_in});
            r_fb_sh         <= STG'({r_fb_sh, bus.fb_in});
            r_ref_d         <= w_ref_s;
            r_fb_d          <= w_fb_s;
            bus.dn_up_o     <= w_ref_s ^ w_fb_s;
            bus.err_valid_o <= 1'b0;
            bus.slip_o      <= 1'b0;
            r_lock_cnt      <= w_lock_nx;
            bus.lock_o      <= (w_lock_nx == LC_MAX);
            case (r_state)
                IDLE: begin
                    if (w_r && w_f) begin
                        bus.phase_err_o <= '0;
                        bus.err_valid_o <= 1'b1;
                    end else if (w_r || w_f) begin
                        r_err_cnt <= CW'(1);
                        r_state   <= w_r ? REF_LEAD : FB_LEAD;
                    end
                end
                default: begin
                    if (w_close) begin
                        bus.phase_err_o <= w_err;
                        bus.err_valid_o <= 1'b1;
                        r_err_cnt       <= CW'(1);
                        if (!w_open) r_state <= IDLE;
                    end else if (w_open) begin
                        bus.slip_o <= 1'b1;
                        r_err_cnt  <= CW'(1);
                    end else if (r_err_cnt == ERR_MAX) begin
                        // Partner edge never arrived: report full-scale error and give up.
                        bus.phase_err_o <= w_err;
                        bus.err_valid_o <= 1'b1;
                        bus.slip_o      <= 1'b1;
                        r_state         <= IDLE;
                    end else begin
                        r_err_cnt <= r_err_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
    dpll_kcounter #(.K_MOD(K_MOD)) u_kcounter (
        .clk_in   (clk_in),
        .rst      (rst),
        .i_en     (bus.en),
        .i_dn_up  (bus.dn_up_o),
        .o_carry  (bus.carry_o),
        .o_borrow (bus.borrow_o)
    );
endmodule
